// File: rtl/reg_datos_pack.sv
// Byte-to-word packer: NSRC prioritised byte sources shift into a W-bit assembly
// register; finished words queue in a DEPTH-entry buffer drained by valid/ready.
// Optional macro REG_DATOS_PARITY_EN adds a stored even-parity bit (word_par) per word.
module reg_datos_pack #(
    parameter int DATA_W = 8,
    parameter int NSRC   = 2,
    parameter int BYTES  = 4,
    parameter int DEPTH  = 4,
    localparam int W     = DATA_W * BYTES,
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int NW    = AW + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NSRC-1:0]          wr_en,
    input  logic [NSRC*DATA_W-1:0]   i_data,
    input  logic                     flush,
    output logic [W-1:0]             outD,
    output logic [CW-1:0]            byte_cnt,
    output logic [W-1:0]             word_data,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic                     full,
    output logic                     ovf
`ifdef REG_DATOS_PARITY_EN
    ,
    output logic                     word_par
`endif
);

    function automatic logic even_parity(input logic [W-1:0] value);
        return ^value;
    endfunction

    logic [W-1:0]        mem_r [DEPTH];
    logic [AW-1:0]       rd_ptr_r;
    logic [AW-1:0]       wr_ptr_r;
    logic [NW-1:0]       count_r;
    logic [W-1:0]        outd_r;
    logic [CW-1:0]       byte_cnt_r;
    logic [W-1:0]        word_data_r;
    logic                word_valid_r;
    logic                full_r;
    logic                ovf_r;
`ifdef REG_DATOS_PARITY_EN
    logic                par_mem_r [DEPTH];
    logic                word_par_r;
    logic                head_par_s;
    logic                push_par_s;
`endif

    logic                wr_req_s;
    logic [DATA_W-1:0]   sel_byte_s;
    logic [W-1:0]        shifted_s;
    logic                pop_s;
    logic                space_s;
    logic                last_s;
    logic                push_s;
    logic [W-1:0]        push_data_s;
    logic [W-1:0]        outd_next_s;
    logic [CW-1:0]       cnt_next_s;
    logic                ovf_set_s;
    logic [NW-1:0]       count_next_s;
    logic [NW-1:0]       remain_s;
    logic [AW-1:0]       rd_next_s;
    logic [AW-1:0]       wr_next_s;
    logic [W-1:0]        head_next_s;

    // Lowest-index requesting source wins; the loop runs high-to-low so it overrides last.
    always_comb begin
        sel_byte_s = '0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (wr_en[k]) begin
                sel_byte_s = i_data[k*DATA_W +: DATA_W];
            end else begin
                sel_byte_s = sel_byte_s;
            end
        end
    end

    assign wr_req_s = |wr_en;

    // A new word always starts from a cleared register, so the first byte zero-extends.
    always_comb begin
        if (byte_cnt_r == '0) begin
            shifted_s = W'(sel_byte_s);
        end else begin
            shifted_s = {outd_r[W-DATA_W-1:0], sel_byte_s};
        end
    end

    assign pop_s   = word_valid_r & word_ready;
    assign space_s = (count_r < NW'(DEPTH)) | pop_s;
    assign last_s  = (byte_cnt_r == CW'(BYTES - 1));

    // Assembly control: flush beats a write; a byte arriving with a flush is always lost.
    always_comb begin
        push_s      = 1'b0;
        push_data_s = outd_r;
        outd_next_s = outd_r;
        cnt_next_s  = byte_cnt_r;
        ovf_set_s   = 1'b0;
        if (flush) begin
            if (byte_cnt_r != '0) begin
                if (space_s) begin
                    push_s      = 1'b1;
                    push_data_s = outd_r;
                    outd_next_s = '0;
                    cnt_next_s  = '0;
                end else begin
                    ovf_set_s = 1'b1;
                end
            end else begin
                outd_next_s = outd_r;
            end
            if (wr_req_s) begin
                ovf_set_s = 1'b1;
            end else begin
                ovf_set_s = ovf_set_s;
            end
        end else if (wr_req_s) begin
            if (last_s) begin
                if (space_s) begin
                    push_s      = 1'b1;
                    push_data_s = shifted_s;
                    outd_next_s = shifted_s;
                    cnt_next_s  = '0;
                end else begin
                    ovf_set_s = 1'b1;
                end
            end else begin
                outd_next_s = shifted_s;
                cnt_next_s  = byte_cnt_r + CW'(1);
            end
        end else begin
            outd_next_s = outd_r;
        end
    end

    // Buffer bookkeeping and next head value, including a push into an emptied buffer.
    always_comb begin
        rd_next_s = rd_ptr_r + AW'(pop_s);
        wr_next_s = wr_ptr_r + AW'(push_s);
        remain_s  = count_r - NW'(pop_s);
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + NW'(1);
            2'b01:   count_next_s = count_r - NW'(1);
            default: count_next_s = count_r;
        endcase
        if (count_next_s == '0) begin
            head_next_s = '0;
        end else if (remain_s == '0) begin
            head_next_s = push_data_s;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

`ifdef REG_DATOS_PARITY_EN
    // Parity travels with each entry so the head bit needs no recomputation.
    always_comb begin
        push_par_s = even_parity(push_data_s);
        if (count_next_s == '0) begin
            head_par_s = 1'b0;
        end else if (remain_s == '0) begin
            head_par_s = push_par_s;
        end else begin
            head_par_s = par_mem_r[rd_next_s];
        end
    end

    // Parity storage and registered head parity.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                par_mem_r[i] <= 1'b0;
            end
            word_par_r <= 1'b0;
        end else begin
            if (push_s) begin
                par_mem_r[wr_ptr_r] <= push_par_s;
            end
            word_par_r <= head_par_s;
        end
    end

    assign word_par = word_par_r;
`endif

    // Main state: assembly register, buffer storage, pointers and status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r     <= '0;
            wr_ptr_r     <= '0;
            count_r      <= '0;
            outd_r       <= '0;
            byte_cnt_r   <= '0;
            word_data_r  <= '0;
            word_valid_r <= 1'b0;
            full_r       <= 1'b0;
            ovf_r        <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
            end
            rd_ptr_r     <= rd_next_s;
            wr_ptr_r     <= wr_next_s;
            count_r      <= count_next_s;
            outd_r       <= outd_next_s;
            byte_cnt_r   <= cnt_next_s;
            word_data_r  <= head_next_s;
            word_valid_r <= (count_next_s != '0);
            full_r       <= (count_next_s == NW'(DEPTH));
            ovf_r        <= ovf_r | ovf_set_s;
        end
    end

    assign outD       = outd_r;
    assign byte_cnt   = byte_cnt_r;
    assign word_data  = word_data_r;
    assign word_valid = word_valid_r;
    assign full       = full_r;
    assign ovf        = ovf_r;

endmodule

// File: tb/tb_reg_datos_pack.sv
// Self-checking bench for reg_datos_pack: directed scenarios plus randomized traffic
// against a byte-list / word-queue reference model.
module tb_reg_datos_pack;
    localparam int DATA_W = 8;
    localparam int NSRC   = 2;
    localparam int BYTES  = 4;
    localparam int DEPTH  = 4;
    localparam int W      = DATA_W * BYTES;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [NSRC-1:0]        wr_en = '0;
    logic [NSRC*DATA_W-1:0] i_data = '0;
    logic                   flush = 1'b0;
    logic [W-1:0]           outD;
    logic [1:0]             byte_cnt;
    logic [W-1:0]           word_data;
    logic                   word_valid;
    logic                   word_ready = 1'b0;
    logic                   full;
    logic                   ovf;
`ifdef REG_DATOS_PARITY_EN
    logic                   word_par;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_part;
    int           m_pc;
    logic [W-1:0] m_outd;
    logic         m_ovf;

    reg_datos_pack #(.DATA_W(DATA_W), .NSRC(NSRC), .BYTES(BYTES), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .i_data(i_data), .flush(flush),
        .outD(outD), .byte_cnt(byte_cnt), .word_data(word_data),
        .word_valid(word_valid), .word_ready(word_ready), .full(full), .ovf(ovf)
`ifdef REG_DATOS_PARITY_EN
        , .word_par(word_par)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit pop, space;
        logic [DATA_W-1:0] b;
        logic [W-1:0] w;
        if (!rst) begin
            m_q.delete();
            m_part = '0; m_pc = 0; m_outd = '0; m_ovf = 1'b0;
            return;
        end
        pop   = (m_q.size() > 0) && word_ready;
        space = (m_q.size() < DEPTH) || pop;
        b = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (wr_en[k]) begin
                b = i_data[k*DATA_W +: DATA_W];
                break;
            end
        end
        if (flush) begin
            if (m_pc != 0) begin
                if (space) begin
                    m_q.push_back(m_part);
                    m_part = '0; m_pc = 0; m_outd = '0;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (wr_en != '0) m_ovf = 1'b1;
        end else if (wr_en != '0) begin
            if (m_pc == BYTES - 1) begin
                if (space) begin
                    w = m_part * 256 + W'(b);
                    m_q.push_back(w);
                    m_outd = w; m_part = '0; m_pc = 0;
                end else begin
                    m_ovf = 1'b1;
                end
            end else begin
                m_part = m_part * 256 + W'(b);
                m_pc++;
                m_outd = m_part;
            end
        end
        if (pop) void'(m_q.pop_front());
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [NSRC-1:0] en, input logic [7:0] d0, input logic [7:0] d1);
        wr_en = en; i_data = {d1, d0};
        cycle();
        wr_en = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0; flush = 1'b0; word_ready = 1'b0;
        cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; wr_en = 2'b11; i_data = 16'hA55A;
        cycle(); cycle();
        n_tests++; if (outD !== '0) begin n_fail++; $display("FAIL reset_outD got %h exp 0", outD); end
        n_tests++; if (byte_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", byte_cnt); end
        n_tests++; if (word_valid !== 1'b0 || full !== 1'b0 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got v%b f%b o%b exp 000", word_valid, full, ovf); end
        n_tests++; if (word_data !== '0) begin n_fail++; $display("FAIL reset_wdata got %h exp 0", word_data); end
        wr_en = '0; rst = 1'b1;
    endtask

    task automatic test_assembly();
        do_reset();
        send(2'b01, 8'h11, 8'h00); send(2'b01, 8'h22, 8'h00); send(2'b01, 8'h33, 8'h00);
        n_tests++; if (word_valid !== 1'b0 || byte_cnt !== 2'd3) begin
            n_fail++; $display("FAIL asm_partial got v%b cnt%0d exp v0 cnt3", word_valid, byte_cnt); end
        send(2'b01, 8'h44, 8'h00);
        n_tests++; if (word_data !== 32'h11223344 || word_valid !== 1'b1) begin
            n_fail++; $display("FAIL asm_word got %h v%b exp 11223344 v1", word_data, word_valid); end
        n_tests++; if (byte_cnt !== 2'd0 || outD !== 32'h11223344) begin
            n_fail++; $display("FAIL asm_after got cnt%0d outD %h exp 0 11223344", byte_cnt, outD); end
    endtask

    task automatic test_priority();
        do_reset();
        send(2'b11, 8'h05, 8'h08);
        n_tests++; if (outD[7:0] !== 8'h05 || byte_cnt !== 2'd1) begin
            n_fail++; $display("FAIL prio_first got %h cnt%0d exp 05 cnt1", outD[7:0], byte_cnt); end
        send(2'b10, 8'h05, 8'h08);
        n_tests++; if (outD[15:0] !== 16'h0508 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL prio_second got %h ovf%b exp 0508 ovf0", outD[15:0], ovf); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4 * BYTES; i++) send(2'b01, 8'(i + 1), 8'h00);
        n_tests++; if (full !== 1'b1 || word_data !== 32'h01020304) begin
            n_fail++; $display("FAIL ovf_full got f%b head %h exp f1 01020304", full, word_data); end
        send(2'b01, 8'hA1, 8'h00); send(2'b01, 8'hA2, 8'h00); send(2'b01, 8'hA3, 8'h00);
        n_tests++; if (byte_cnt !== 2'd3 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL ovf_pre got cnt%0d o%b exp cnt3 o0", byte_cnt, ovf); end
        send(2'b01, 8'hA4, 8'h00);
        n_tests++; if (ovf !== 1'b1 || byte_cnt !== 2'd3 || outD !== 32'h00A1A2A3) begin
            n_fail++; $display("FAIL ovf_drop got o%b cnt%0d outD %h exp o1 cnt3 00a1a2a3", ovf, byte_cnt, outD); end
        word_ready = 1'b1;
        send(2'b01, 8'hA4, 8'h00);
        word_ready = 1'b0;
        n_tests++; if (full !== 1'b1 || byte_cnt !== 2'd0 || ovf !== 1'b1 || word_data !== 32'h05060708) begin
            n_fail++; $display("FAIL ovf_pushpop got f%b cnt%0d o%b head %h exp f1 cnt0 o1 05060708",
                               full, byte_cnt, ovf, word_data); end
    endtask

    task automatic test_flush();
        do_reset();
        send(2'b01, 8'hAA, 8'h00); send(2'b01, 8'hBB, 8'h00);
        flush = 1'b1; cycle(); flush = 1'b0;
        n_tests++; if (word_data !== 32'h0000AABB || word_valid !== 1'b1) begin
            n_fail++; $display("FAIL flush_word got %h v%b exp 0000aabb v1", word_data, word_valid); end
        n_tests++; if (byte_cnt !== 2'd0 || outD !== '0) begin
            n_fail++; $display("FAIL flush_clear got cnt%0d outD %h exp 0 0", byte_cnt, outD); end
        send(2'b01, 8'hCC, 8'h00);
        flush = 1'b1; send(2'b01, 8'hDD, 8'h00); flush = 1'b0;
        n_tests++; if (ovf !== 1'b1 || byte_cnt !== 2'd0 || outD !== '0) begin
            n_fail++; $display("FAIL flush_wr got o%b cnt%0d outD %h exp o1 0 0", ovf, byte_cnt, outD); end
    endtask

    task automatic test_reset_midword();
        do_reset();
        for (int i = 0; i < BYTES + 2; i++) send(2'b01, 8'(8'h30 + i), 8'h00);
        rst = 1'b0; cycle(); rst = 1'b1;
        n_tests++; if (word_valid !== 1'b0 || outD !== '0 || byte_cnt !== 2'd0 || full !== 1'b0) begin
            n_fail++; $display("FAIL midrst got v%b outD %h cnt%0d f%b exp 0", word_valid, outD, byte_cnt, full); end
`ifdef REG_DATOS_PARITY_EN
        send(2'b01, 8'h00, 8'h00); send(2'b01, 8'h00, 8'h00);
        send(2'b01, 8'h00, 8'h00); send(2'b01, 8'h01, 8'h00);
        n_tests++; if (word_par !== 1'b1 || word_data !== 32'h1) begin
            n_fail++; $display("FAIL parity got p%b %h exp p1 00000001", word_par, word_data); end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst        = ($urandom_range(0, 63) != 0);
            wr_en      = NSRC'($urandom_range(0, 3));
            i_data     = 16'($urandom);
            flush      = ($urandom_range(0, 9) == 0);
            word_ready = ($urandom_range(0, 2) != 0);
            cycle();
            n_tests++; if (outD !== m_outd || byte_cnt !== 2'(m_pc)) begin
                n_fail++; $display("FAIL rnd_asm c%0d got %h/%0d exp %h/%0d", c, outD, byte_cnt, m_outd, m_pc); end
            n_tests++; if (word_valid !== (m_q.size() != 0) || full !== (m_q.size() == DEPTH) || ovf !== m_ovf) begin
                n_fail++; $display("FAIL rnd_flags c%0d got v%b f%b o%b exp occ%0d o%b",
                                   c, word_valid, full, ovf, m_q.size(), m_ovf); end
            n_tests++; if (word_data !== ((m_q.size() != 0) ? m_q[0] : '0)) begin
                n_fail++; $display("FAIL rnd_head c%0d got %h exp %h", c, word_data,
                                   (m_q.size() != 0) ? m_q[0] : '0); end
`ifdef REG_DATOS_PARITY_EN
            n_tests++; if (word_par !== ((m_q.size() != 0) ? ^m_q[0] : 1'b0)) begin
                n_fail++; $display("FAIL rnd_par c%0d got %b", c, word_par); end
`endif
        end
        rst = 1'b1; wr_en = '0; flush = 1'b0; word_ready = 1'b0;
    endtask

    initial begin
        m_part = '0; m_pc = 0; m_outd = '0; m_ovf = 1'b0;
        test_reset();
        test_assembly();
        test_priority();
        test_overflow();
        test_flush();
        test_reset_midword();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_datos_pack.md
Name: reg_datos_pack

Overview:
Parametrised successor to the two-source data register. It accepts bytes from NSRC write-enabled sources and shifts them into a word-wide assembly register. Each completed word is queued in a DEPTH-entry output buffer and drained with a valid/ready handshake. It sits between the internal and external data producers and the word-wide consumer.

Parameters:
DATA_W, 8, width of one source byte
NSRC, 2, number of byte sources (index 0 = internal, 1 = external, further indices free)
BYTES, 4, bytes per assembled word; word width W = DATA_W*BYTES
DEPTH, 4, output buffer entries (power of 2, >= 2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-low reset
wr_en  in  NSRC  per-source write enable
i_data  in  NSRC*DATA_W  source bytes; source k occupies bits [k*DATA_W +: DATA_W]
flush  in  1  push a partial word
outD  out  W  live assembly register
byte_cnt  out  clog2(BYTES)  number of bytes held in the current partial word
word_data  out  W  head of the output buffer
word_valid  out  1  output buffer is non-empty
word_ready  in  1  consumer accepts the head word
full  out  1  output buffer holds DEPTH words
ovf  out  1  sticky drop flag

Behaviour:
- Reset (rst=0 at a clock edge): outD=0, byte_cnt=0, buffer emptied, word_valid=0, full=0, ovf=0, word_data=0. rst has priority over every other input.
- Source selection: any wr_en bit set means a write request. The lowest set index wins; other requesting sources are ignored and do not set ovf.
- Accepted byte: outD <= {outD[W-DATA_W-1:0], byte}, so the newest byte lands in the LSBs. byte_cnt increments.
- Word completion: when a byte is accepted with byte_cnt==BYTES-1, the new shifted value is pushed into the buffer on the same edge and byte_cnt becomes 0. outD keeps the completed word until the next byte shifts in.
  - word_valid rises on the cycle after the completing edge (1-cycle latency).
- Pop: occurs when word_valid && word_ready; the head advances on that edge.
- Push and pop in the same cycle are legal in any state, including full. Occupancy is then unchanged.
- Space check: push allowed if occupancy < DEPTH, or if a pop happens in the same cycle.
- Completing byte with no space: the byte is dropped, outD and byte_cnt are unchanged, and ovf is set to 1. ovf stays 1 until reset.
- Non-completing bytes are always accepted.
- Flush:
  - byte_cnt != 0: push outD as-is (partial word, zeros in the unfilled upper bytes from the cleared register) and set byte_cnt=0. outD is then cleared to 0.
  - byte_cnt == 0: no-op.
  - Flush with no space: flush is ignored and ovf is set.
- Flush and a write in the same cycle: flush wins, the byte is dropped, and ovf is set.
- Clearing rule: after every completed or flushed push, the next word starts from a cleared register. outD is cleared at the start of each new word (on the first byte, byte_cnt==0, the upper bytes are forced to 0).
- full = (occupancy == DEPTH), registered.
- Buffer pointers wrap modulo DEPTH. Occupancy is held in a clog2(DEPTH)+1-bit counter.

Optional Feature:
REG_DATOS_PARITY_EN
- Defined: adds output port word_par (1 bit) carrying the even parity (XOR) of word_data. Parity is computed at push and stored alongside each buffer entry. word_par is 0 at reset and 0 while the buffer is empty.
- Undefined: the port and the parity storage are absent. All other behaviour is identical.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with wr_en=2'b11 -> outD=0, byte_cnt=0, word_valid=0, full=0, ovf=0.
2. Assembly: wr_en=2'b01, src0 = 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> word_data=0x11223344, word_valid=1 one cycle after the 4th byte, byte_cnt=0.
3. Priority: wr_en=2'b11, src0=0x05, src1=0x08 -> outD[7:0]=0x05, byte_cnt=1. Then wr_en=2'b10 -> outD[15:0]=0x0508.
4. Overflow: word_ready=0, push 4 words -> full=1. Send 3 more bytes, then a 4th with ready=0 -> byte dropped, ovf=1, byte_cnt stays 3. Repeat the 4th with ready=1 -> accepted, full stays 1.
5. Flush: bytes 0xAA, 0xBB, then flush=1 -> word 0x0000AABB queued, byte_cnt=0, outD=0. Flush together with a write -> byte dropped, ovf=1.
6. Reset mid-word: after 2 bytes and 1 queued word, rst=0 for 1 cycle -> buffer empty, outD=0, byte_cnt=0. With REG_DATOS_PARITY_EN, word 0x00000001 -> word_par=1.
